// File: rtl/writeback_unit.sv
// Register write-back stage: FIFO-buffered ALU/load results, one retire per cycle,
// pending scoreboard and halt drain. Optional same-cycle bypass via `WB_BYPASS_EN.
module writeback_unit #(
  parameter int NUMREGISTERS = 8,
  parameter int DATAW        = 32,
  parameter int REGW         = 3,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [REGW-1:0]         alu_reg,
  input  logic [DATAW-1:0]        alu_data,
  input  logic                    mem_valid,
  input  logic [REGW-1:0]         mem_reg,
  input  logic [DATAW-1:0]        mem_data,
  input  logic                    mark_en,
  input  logic [REGW-1:0]         mark_reg,
  input  logic                    halt_in,
  output logic [REGW-1:0]         wr_reg,
  output logic [DATAW-1:0]        wr_data,
  output logic                    reg_wr_en,
  output logic [NUMREGISTERS-1:0] pending,
  output logic                    stall,
  output logic                    overflow,
  output logic                    halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t                  state_q, state_d;
  logic [REGW-1:0]         fifo_reg_q  [DEPTH];
  logic [REGW-1:0]         fifo_reg_d  [DEPTH];
  logic [DATAW-1:0]        fifo_data_q [DEPTH];
  logic [DATAW-1:0]        fifo_data_d [DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot;
  logic [CW-1:0]           count_q, count_d, free;
  logic [REGW-1:0]         wr_reg_q, wr_reg_d;
  logic [DATAW-1:0]        wr_data_q, wr_data_d;
  logic                    reg_wr_en_q, reg_wr_en_d;
  logic [NUMREGISTERS-1:0] pending_q, pending_d;
  logic                    overflow_q, overflow_d;

  logic in_mem, in_alu, pop, byp_mem, byp_alu;
  logic push_mem_req, push_alu_req, push_mem, push_alu;

  always_comb begin
    in_mem  = (state_q != ST_HALTED) && mem_valid;
    in_alu  = (state_q != ST_HALTED) && alu_valid;
    pop     = (count_q != '0);
    byp_mem = 1'b0;
    byp_alu = 1'b0;
`ifdef WB_BYPASS_EN
    // With an empty FIFO the mem result takes the bypass; a simultaneous alu result queues.
    if (count_q == '0) begin
      if (in_mem)      byp_mem = 1'b1;
      else if (in_alu) byp_alu = 1'b1;
    end
`endif
    push_mem_req = in_mem && !byp_mem;
    push_alu_req = in_alu && !byp_alu;

    // The same-cycle pop frees its slot before pushes are admitted.
    free     = CW'(DEPTH) - count_q + CW'(pop);
    push_mem = push_mem_req && (free != '0);
    push_alu = push_alu_req && (free > CW'(push_mem));

    overflow_d = overflow_q
               | (push_mem_req && !push_mem)
               | (push_alu_req && !push_alu);

    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    alu_slot    = wr_ptr_q + PW'(push_mem);
    if (push_mem) begin
      fifo_reg_d[wr_ptr_q]  = mem_reg;
      fifo_data_d[wr_ptr_q] = mem_data;
    end
    if (push_alu) begin
      fifo_reg_d[alu_slot]  = alu_reg;
      fifo_data_d[alu_slot] = alu_data;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_mem) + PW'(push_alu);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);

    reg_wr_en_d = pop || byp_mem || byp_alu;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    if (pop) begin
      wr_reg_d  = fifo_reg_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end else if (byp_mem) begin
      wr_reg_d  = mem_reg;
      wr_data_d = mem_data;
    end else if (byp_alu) begin
      wr_reg_d  = alu_reg;
      wr_data_d = alu_data;
    end

    // Clear first so a colliding mark on the same register wins.
    pending_d = pending_q;
    if (reg_wr_en_d) pending_d[wr_reg_d] = 1'b0;
    if (mark_en && (state_q == ST_RUN)) pending_d[mark_reg] = 1'b1;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (halt_in) state_d = ST_DRAIN;
      ST_DRAIN: if ((count_q == '0) && !mem_valid && !alu_valid && !reg_wr_en_q
                    && (pending_q == '0)) state_d = ST_HALTED;
      default:  state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      reg_wr_en_q <= 1'b0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      reg_wr_en_q <= reg_wr_en_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_reg_q  <= fifo_reg_d;
    fifo_data_q <= fifo_data_d;
  end

  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign reg_wr_en = reg_wr_en_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign stall     = (count_q >= CW'(DEPTH - 2)) || (state_q != ST_RUN);
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register write-back stage for the core pipeline. It collects completed results from the ALU (single-cycle) and the memory load return path (variable latency) and buffers them in a small FIFO. It retires one register write per cycle onto the decode stage's register-file write port (`wr_reg`, `wr_data`, `reg_wr_en`). It also keeps a per-register pending scoreboard for hazard stalls and runs the halt drain sequence.

## Interface
Parameters:
- `NUMREGISTERS`, 8: architectural registers; scoreboard width.
- `DATAW`, 32: result data width.
- `REGW`, 3: register index width; `2**REGW == NUMREGISTERS`.
- `DEPTH`, 4: FIFO entries; power of two, ≥4.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `alu_valid`, `alu_reg`, `alu_data`  in  1/REGW/DATAW  ALU result this cycle.
- `mem_valid`, `mem_reg`, `mem_data`  in  1/REGW/DATAW  load result this cycle.
- `mark_en`, `mark_reg`  in  1/REGW  decode issued an instruction writing `mark_reg`.
- `halt_in`  in  1  halt instruction decoded; level or pulse.
- `wr_reg`  out  REGW  write index to the register file.
- `wr_data`  out  DATAW  write data.
- `reg_wr_en`  out  1  write strobe.
- `pending`  out  NUMREGISTERS  scoreboard; bit i means register i has a write outstanding.
- `stall`  out  1  upstream must not issue.
- `overflow`  out  1  sticky error flag.
- `halted`  out  1  drain complete.

## Operation
- **FIFO entries:** each entry is {reg, data}.
  - Per cycle, pushes occur in source order: mem first, then alu.
  - One pop per cycle when non-empty. The popped entry loads the registered outputs `wr_reg`/`wr_data`, and `reg_wr_en` is 1 for that cycle.
  - `reg_wr_en` is 0 in any cycle with no pop.
- **Count arithmetic:** count_next = count + pushes − pop. Push and pop in the same cycle are legal, including on a full FIFO, because the pop frees its slot first.
- **Overflow:** if the pushes would exceed free space after the pop, excess entries are dropped, alu first. `overflow` is set and held until `rst`.
- **Stall:** `stall` = (count ≥ DEPTH−2) OR state ≠ RUN. It is combinational from registered state.
- **Scoreboard:**
  - `mark_en` sets `pending[mark_reg]`.
  - A pop with `reg_wr_en` clears `pending[wr_reg]` on the edge that loads the write.
  - If mark and clear hit the same register in the same cycle, the mark wins and the bit stays 1.
  - `mark_en` is ignored outside RUN.
- **State machine** (RUN, DRAIN, HALTED):
  - RUN → DRAIN when `halt_in`=1.
  - DRAIN → HALTED when all of these hold: FIFO empty, no valid input, no write retiring this cycle, `pending`==0.
  - HALTED holds until `rst`. In HALTED, `halted`=1 and inputs are ignored; nothing is pushed.
  - `halt_in` in DRAIN or HALTED has no effect.

## Timing
- **Reset values:** `wr_reg`=0, `wr_data`=0, `reg_wr_en`=0, `pending`=0, `stall`=0, `overflow`=0, `halted`=0. State is RUN and count is 0.
- **Reset mid-operation:** FIFO contents are discarded. Any in-flight input on the reset cycle is dropped.
- **Latency, bypass disabled:** a result valid at edge N is pushed at N. It loads the outputs at edge N+1 if it is at the head, so `reg_wr_en` is high in cycle N+1→N+2. That is 2 edges from input to register-file write edge.
- **Ordering:** writes retire strictly in push order. Mem precedes alu within a cycle.
- **Throughput:** 1 write/cycle sustained. Two sources simultaneously valid grow the FIFO by 1/cycle.

## Configuration
- **Macro `WB_BYPASS_EN`:** when defined, if the FIFO is empty (before the pop) and exactly one source is valid, that result loads the output registers directly at edge N and is not pushed. Latency is then 1 edge and the scoreboard clears at edge N.
- **Both sources valid:** the mem result bypasses and the alu result is pushed.
- **Not defined:** every result goes through the FIFO with 2-edge latency.
- Behaviour is otherwise identical with or without the macro.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles while `alu_valid`=1 (reg 3, 0xDEAD) → all outputs 0, no write after release, `pending`=0.
- **Single ALU write:** `mark_en` reg 5, then `alu_valid` reg 5 data 0x12345678 at edge N → `reg_wr_en`=1 with `wr_reg`=5, `wr_data`=0x12345678 after N+1 (after N with `WB_BYPASS_EN`). `pending[5]` goes 1 then 0.
- **Dual push and ordering:** mem (reg 1, 0xA) and alu (reg 2, 0xB) valid on 3 consecutive cycles → writes retire 1, 2, 1, 2, 1, 2 back-to-back. `stall` rises when count reaches 2 (DEPTH=4). No overflow.
- **Forced overflow:** ignore `stall` and drive both sources valid for 4 cycles → `overflow`=1 and stays 1. Only DEPTH entries (plus pops) retire, and dropped entries are alu entries.
- **Mark/clear collision:** reg 4 pending and retiring in the same cycle as `mark_en` reg 4 → `pending[4]` stays 1.
- **Halt drain:** 3 entries queued, then `halt_in` pulse → `stall`=1 immediately. All 3 writes retire, then `halted`=1 on the following edge. A later `alu_valid` produces no write.
